// File: rtl/hall_call_arbiter.sv
// Hall-call latch and arbiter: holds presses as pending bits and grants one at a time (fixed or round-robin).
// Press-to-grant 2 cycles; a grant holds stable until done, so at most one grant per 2 cycles.
module hall_call_arbiter #(
    parameter int NUM_FLOORS = 4,
    parameter int NUM_REQ    = 2 * (NUM_FLOORS - 1),
    parameter int CNT_W      = $clog2(NUM_REQ + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req_in,
    input  logic               mode,
    input  logic               done,
    output logic [NUM_REQ-1:0] grant_out,
    output logic               grant_valid,
    output logic [NUM_REQ-1:0] pending,
    output logic [CNT_W-1:0]   pend_count,
    output logic               q_empty
);
    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             state_q, state_d;
    logic [NUM_REQ-1:0] p_q, p_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic               gvld_q, gvld_d;
    logic [IDX_W-1:0]   rr_q, rr_d;

    logic [NUM_REQ-1:0] clr;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
    logic [IDX_W-1:0]   gnt_idx;

    // Winner search walks indices from rr_q (round-robin) or from 0 (fixed), first hit wins.
    always_comb begin
        int j;
        j         = 0;
        win_found = 1'b0;
        win_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            j = mode ? (int'(rr_q) + i) % NUM_REQ : i;
            if (!win_found && p_q[j]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_q[i]) gnt_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gvld_d  = gvld_q;
        rr_d    = rr_q;
        clr     = '0;
        case (state_q)
            IDLE: begin
                if (win_found) begin
                    grant_d = '0;
                    grant_d[win_idx] = 1'b1;
                    gvld_d  = 1'b1;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (done) begin
                    clr     = grant_q;
                    grant_d = '0;
                    gvld_d  = 1'b0;
                    rr_d    = (int'(gnt_idx) == NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A re-press landing on the acceptance edge survives the clear.
        p_d = (p_q & ~clr) | req_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            grant_q <= '0;
            gvld_q  <= 1'b0;
            rr_q    <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            grant_q <= grant_d;
            gvld_q  <= gvld_d;
            rr_q    <= rr_d;
        end
    end

    assign grant_out   = grant_q;
    assign grant_valid = gvld_q;
    assign pending     = p_q;
    assign pend_count  = CNT_W'($countones(p_q));
    assign q_empty     = (p_q == '0);

endmodule
